// File: rtl/icache_pkg.sv
// Shared geometry, address-field helpers and FSM encoding for the set-associative I-cache.
package icache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SETS       = 64;
    localparam int unsigned WAYS       = 2;
    localparam int unsigned LINE_WORDS = 4;

    localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
    localparam int unsigned IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int unsigned TAG_W    = ADDR_W - 2 - OFF_BITS - IDX_BITS;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [0:0] state_t;
    localparam state_t S_IDLE   = 1'b0;
    localparam state_t S_REFILL = 1'b1;

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return OFF_W'((a >> 2) & ADDR_W'(LINE_WORDS - 1));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a >> (2 + OFF_BITS)) & ADDR_W'(SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (2 + OFF_BITS + IDX_BITS));
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(LINE_WORDS * 4 - 1);
    endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signals of the I-cache, grouped for port connection.
interface icache_sa_if;
    logic                             flush_i;
    logic                             inval_i;
    logic                             req_i;
    logic [icache_pkg::ADDR_W-1:0]    addr_i;
    logic [icache_pkg::DATA_W-1:0]    data_o;
    logic                             done_o;
    logic                             mem_req_o;
    logic [icache_pkg::ADDR_W-1:0]    mem_addr_o;
    logic [icache_pkg::DATA_W-1:0]    mem_data_i;
    logic                             mem_done_i;
    logic                             mem_wait_i;

    modport slave (
        input  flush_i, inval_i, req_i, addr_i, mem_data_i, mem_done_i, mem_wait_i,
        output data_o, done_o, mem_req_o, mem_addr_o
    );

    modport master (
        output flush_i, inval_i, req_i, addr_i, mem_data_i, mem_done_i, mem_wait_i,
        input  data_o, done_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_way.sv
// One cache way: valid bits, tag array and line data, with comb read and sync write.
module icache_way
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [OFF_W-1:0]  i_rd_off,
    output logic              o_valid,
    output logic [TAG_W-1:0]  o_tag,
    output logic [DATA_W-1:0] o_word,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [OFF_W-1:0]  i_wr_off,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_set_en,
    input  logic [TAG_W-1:0]  i_set_tag,
    input  logic              i_clr_en,
    input  logic [IDX_W-1:0]  i_clr_idx,
    input  logic              i_inval_all
);
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [DATA_W-1:0] r_data [SETS][LINE_WORDS];

    assign o_valid = r_valid[i_rd_idx];
    assign o_tag   = r_tag[i_rd_idx];
    assign o_word  = r_data[i_rd_idx][i_rd_off];

    always_ff @(posedge clk) begin
        if (rst || i_inval_all) begin
            r_valid <= '0;
        end else begin
            if (i_set_en) r_valid[i_wr_idx]  <= 1'b1;
            if (i_clr_en) r_valid[i_clr_idx] <= 1'b0;
        end
    end

    // Arrays carry no reset; the valid bits alone gate visibility.
    always_ff @(posedge clk) begin
        if (i_set_en) r_tag[i_wr_idx] <= i_set_tag;
        if (i_wr_en)  r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
endmodule

// File: rtl/icache_sa.sv
// Set-associative I-cache top: lookup/hit mux, victim choice, line refill FSM, abort and invalidate.
module icache_sa
    import icache_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    icache_sa_if.slave   bus
);
    state_t              r_state, w_next;
    logic [OFF_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [IDX_W-1:0]    r_idx;
    logic [TAG_W-1:0]    r_tag;
    logic [WAY_W-1:0]    r_victim;
    logic                r_from_rr;
    logic [WAY_W-1:0]    r_rr [SETS];

    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_valid    [WAYS];
    logic [TAG_W-1:0]    w_way_tag  [WAYS];
    logic [DATA_W-1:0]   w_way_word [WAYS];
    logic                w_hit;
    logic [DATA_W-1:0]   w_hit_word;
    logic [WAY_W-1:0]    w_victim;
    logic                w_vic_rr;
    logic                w_start, w_take, w_last, w_abort;
    logic [WAYS-1:0]     w_wr_en, w_set_en, w_clr_en;

    assign w_off = addr_off(bus.addr_i);
    assign w_idx = addr_idx(bus.addr_i);
    assign w_tag = addr_tag(bus.addr_i);

    for (genvar g = 0; g < int'(WAYS); g++) begin : g_way
        icache_way u_way (
            .clk         (clk),
            .rst         (rst),
            .i_rd_idx    (w_idx),
            .i_rd_off    (w_off),
            .o_valid     (w_valid[g]),
            .o_tag       (w_way_tag[g]),
            .o_word      (w_way_word[g]),
            .i_wr_en     (w_wr_en[g]),
            .i_wr_idx    (r_idx),
            .i_wr_off    (r_cnt),
            .i_wr_data   (bus.mem_data_i),
            .i_set_en    (w_set_en[g]),
            .i_set_tag   (r_tag),
            .i_clr_en    (w_clr_en[g]),
            .i_clr_idx   (w_idx),
            .i_inval_all (bus.inval_i)
        );
    end

    // Hit mux and victim choice: lowest invalid way, else the set's round-robin pointer.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_word = '0;
        w_victim   = r_rr[w_idx];
        w_vic_rr   = 1'b1;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!w_hit && w_valid[w] && (w_way_tag[w] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_word = w_way_word[w];
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!w_valid[w]) begin
                w_victim = WAY_W'(w);
                w_vic_rr = 1'b0;
            end
        end
    end

    assign w_abort = bus.inval_i || bus.flush_i;
    assign w_start = (r_state == S_IDLE) && bus.req_i && !w_hit && !w_abort;
    assign w_take  = (r_state == S_REFILL) && bus.mem_done_i && !w_abort;
    assign w_last  = w_take && (r_cnt == OFF_W'(LINE_WORDS - 1));

    always_comb begin
        w_wr_en  = '0;
        w_set_en = '0;
        w_clr_en = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            w_wr_en[w]  = w_take  && (r_victim == WAY_W'(w));
            w_set_en[w] = w_last  && (r_victim == WAY_W'(w));
            w_clr_en[w] = w_start && (w_victim == WAY_W'(w));
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_next = S_REFILL;
            S_REFILL: if (w_abort || w_last) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_mem_addr <= '0;
            r_idx      <= '0;
            r_tag      <= '0;
            r_victim   <= '0;
            r_from_rr  <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) r_rr[s] <= '0;
        end else if (w_start) begin
            r_cnt      <= '0;
            r_mem_addr <= line_base(bus.addr_i);
            r_idx      <= w_idx;
            r_tag      <= w_tag;
            r_victim   <= w_victim;
            r_from_rr  <= w_vic_rr;
        end else if (w_take) begin
            r_cnt      <= r_cnt + OFF_W'(1);
            r_mem_addr <= r_mem_addr + ADDR_W'(4);
            if (w_last && r_from_rr && (WAYS > 1)) r_rr[r_idx] <= r_victim + WAY_W'(1);
        end
    end

    assign bus.done_o     = rst || !bus.req_i || w_hit;
    assign bus.data_o     = (!rst && bus.req_i && w_hit) ? w_hit_word : '0;
    assign bus.mem_req_o  = !rst && (r_state == S_REFILL) && !bus.mem_wait_i;
    assign bus.mem_addr_o = r_mem_addr;
endmodule

// File: tb/tb_icache_sa.sv
// Directed + randomized bench for icache_sa against a line-level cache model.
module tb_icache_sa;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    icache_sa_if bus ();

    icache_sa dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: per set/way a valid flag and the cached line number (addr >> 4).
    bit          m_valid [SETS][WAYS];
    logic [27:0] m_line  [SETS][WAYS];
    int          m_rr    [SETS];

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return {~w[15:0], w[15:0]} ^ 32'h5A3C_0000;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 4) % SETS);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s;
        s = set_of(a);
        for (int w = 0; w < int'(WAYS); w++)
            if (m_valid[s][w] && m_line[s][w] == a[31:4]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_clear(input bit rr_too);
        for (int s = 0; s < int'(SETS); s++) begin
            for (int w = 0; w < int'(WAYS); w++) m_valid[s][w] = 1'b0;
            if (rr_too) m_rr[s] = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch with bench-driven memory. abort_kind: 0 none, 1 flush, 2 inval, 3 rst, applied at word abort_at.
    task automatic fetch(input logic [31:0] a, input int abort_kind, input int abort_at, input int long_wait_at);
        logic [31:0] base;
        int s, v;
        bit hit, from_rr;
        base = a & ~32'hF;
        s    = set_of(a);
        hit  = m_hit(a);
        @(negedge clk);
        bus.req_i = 1'b1; bus.addr_i = a; bus.mem_done_i = 1'b0;
        #1;
        check("lookup_done", 32'(bus.done_o), 32'(hit));
        if (hit) begin
            check("hit_data", bus.data_o, mem_fn(a));
            check("hit_no_memreq", 32'(bus.mem_req_o), 32'd0);
            bus.req_i = 1'b0;
            return;
        end
        check("miss_data", bus.data_o, 32'd0);
        v = -1;
        for (int w = 0; w < int'(WAYS); w++) if (v < 0 && !m_valid[s][w]) v = w;
        from_rr = (v < 0);
        if (from_rr) v = m_rr[s];
        m_valid[s][v] = 1'b0;
        for (int k = 0; k < int'(LINE_WORDS); k++) begin
            int nw;
            nw = (k == long_wait_at) ? 5 : int'($urandom_range(0, 2));
            for (int c = 0; c < nw; c++) begin
                @(negedge clk);
                bus.mem_done_i = 1'b0; bus.mem_wait_i = 1'b1;
                #1;
                check("wait_no_req", 32'(bus.mem_req_o), 32'd0);
                check("wait_addr", bus.mem_addr_o, base + 32'(4 * k));
                check("wait_done", 32'(bus.done_o), 32'd0);
            end
            @(negedge clk);
            bus.mem_done_i = 1'b0; bus.mem_wait_i = 1'b0;
            if (abort_kind != 0 && k == abort_at) begin
                bus.mem_done_i = 1'b1; bus.mem_data_i = mem_fn(base + 32'(4 * k));
                bus.flush_i = (abort_kind == 1);
                bus.inval_i = (abort_kind == 2);
                rst         = (abort_kind == 3);
                #1;
                if (abort_kind == 3) begin
                    check("rst_done", 32'(bus.done_o), 32'd1);
                    check("rst_data", bus.data_o, 32'd0);
                    check("rst_memreq", 32'(bus.mem_req_o), 32'd0);
                end
                @(negedge clk);
                bus.flush_i = 1'b0; bus.inval_i = 1'b0; rst = 1'b0;
                bus.mem_done_i = 1'b0; bus.req_i = 1'b0;
                #1;
                check("abort_memreq", 32'(bus.mem_req_o), 32'd0);
                check("abort_done", 32'(bus.done_o), 32'd1);
                check("abort_data", bus.data_o, 32'd0);
                if (abort_kind == 3) check("rst_memaddr", bus.mem_addr_o, 32'd0);
                if (abort_kind >= 2) m_clear(abort_kind == 3);
                return;
            end
            #1;
            check("refill_req", 32'(bus.mem_req_o), 32'd1);
            check("refill_addr", bus.mem_addr_o, base + 32'(4 * k));
            check("refill_done", 32'(bus.done_o), 32'd0);
            bus.mem_done_i = 1'b1; bus.mem_data_i = mem_fn(base + 32'(4 * k));
        end
        @(negedge clk);
        bus.mem_done_i = 1'b0; bus.mem_data_i = $urandom;
        #1;
        m_valid[s][v] = 1'b1;
        m_line[s][v]  = a[31:4];
        if (from_rr) m_rr[s] = (m_rr[s] + 1) % int'(WAYS);
        check("fill_done", 32'(bus.done_o), 32'd1);
        check("fill_data", bus.data_o, mem_fn(a));
        check("fill_no_req", 32'(bus.mem_req_o), 32'd0);
        bus.req_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; bus.req_i = 1'b0;
        @(negedge clk);
        #1;
        check("reset_done", 32'(bus.done_o), 32'd1);
        check("reset_data", bus.data_o, 32'd0);
        check("reset_memreq", 32'(bus.mem_req_o), 32'd0);
        check("reset_memaddr", bus.mem_addr_o, 32'd0);
        rst = 1'b0;
        m_clear(1'b1);
    endtask

    initial begin
        int idxs[3];
        logic [31:0] a;
        idxs[0] = 0; idxs[1] = 3; idxs[2] = 63;
        rst = 1'b1;
        bus.flush_i = 1'b0; bus.inval_i = 1'b0; bus.req_i = 1'b0; bus.addr_i = '0;
        bus.mem_data_i = '0; bus.mem_done_i = 1'b0; bus.mem_wait_i = 1'b0;
        do_reset();

        // Cold miss, then same-line hits
        fetch(32'h1000, 0, 0, -1);
        fetch(32'h1004, 0, 0, -1);
        fetch(32'h1008, 0, 0, -1);
        fetch(32'h100C, 0, 0, -1);

        // Two ways of set 0, then round-robin eviction of way0
        do_reset();
        fetch(32'h0000, 0, 0, -1);
        fetch(32'h4000, 0, 0, -1);
        fetch(32'h8004, 0, 0, -1);
        fetch(32'h4008, 0, 0, -1);
        fetch(32'h0000, 0, 0, -1);

        // Flush after two words (concurrent done dropped), then refetch from line base
        fetch(32'h2000, 1, 2, -1);
        fetch(32'h2000, 0, 0, -1);
        fetch(32'h200C, 0, 0, -1);

        // Long memory stall mid-refill
        fetch(32'h3010, 0, 0, 2);
        fetch(32'h3018, 0, 0, -1);

        // Invalidate in idle, then invalidate concurrent with a done
        fetch(32'h1000, 0, 0, -1);
        @(negedge clk);
        bus.inval_i = 1'b1;
        @(negedge clk);
        bus.inval_i = 1'b0;
        m_clear(1'b0);
        fetch(32'h1000, 2, 1, -1);
        fetch(32'h2004, 0, 0, -1);
        fetch(32'h1004, 0, 0, -1);

        // Reset mid-refill, then a previously cached line misses
        fetch(32'h3040, 0, 0, -1);
        fetch(32'h5040, 3, 2, -1);
        fetch(32'h3040, 0, 0, -1);

        // Random traffic over a few conflicting sets with occasional flushes
        for (int i = 0; i < 80; i++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'(idxs[$urandom_range(0, 2)]) << 4)
              | 32'($urandom_range(0, 15));
            fetch(a, ($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 3)), -1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
